fetch_queue: RTL

- Parametrised successor to the single-register fetch stage.
- Decouples instruction-memory latency from decode using a DEPTH-entry prefetch queue of {pc, inst} pairs.
- Issues sequential fetch requests with credit-based flow control, tolerates in-order multi-cycle memory responses, and supports same-cycle redirect (branch/jump) with squashing of stale in-flight responses.
- Sits between the instruction memory port and decode; decode back-pressure via inst_ready_i replaces the old halt input.

---
 rtl/fetch_queue_if.sv | 31 +++
 rtl/fetch_queue.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-stage bundle: instruction-memory request/response, decode handshake and redirect.
// master is the fetch queue itself; slave is the memory/decode environment around it.
interface fetch_queue_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic            redirect_i;
   logic [XLEN-1:0] redirect_pc_i;
   logic            imem_req_o;
   logic [XLEN-1:0] imem_addr_o;
   logic            imem_gnt_i;
   logic            imem_rvalid_i;
   logic [XLEN-1:0] imem_rdata_i;
   logic            inst_valid_o;
   logic [XLEN-1:0] inst_o;
   logic [XLEN-1:0] pc_o;
   logic            inst_ready_i;
   logic [CW-1:0]   count_o;

   modport master (
      input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
      output imem_req_o, imem_addr_o, inst_valid_o, inst_o, pc_o, count_o
   );

   modport slave (
      output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
      input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, pc_o, count_o
   );
endinterface

// File: rtl/fetch_queue.sv
// Prefetch queue between instruction memory and decode: credit-limited sequential fetch,
// in-order response capture into a DEPTH-entry ring, and redirect with stale-response squashing.
module fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input logic           clk,
   input logic           rst,
   fetch_queue_if.master bus
);
   localparam int              CW      = $clog2(DEPTH + 1);
   localparam int              PW      = $clog2(DEPTH);
   localparam logic [XLEN-1:0] STEP    = XLEN'(3'd4);
   localparam logic [XLEN-1:0] ZERO_X  = {XLEN{1'b0}};
   localparam logic [XLEN-1:0] ALIGN_M = ~(XLEN'(2'b11));
   localparam logic [CW:0]     DEPTH_C = (CW + 1)'(DEPTH);
   localparam logic [CW-1:0]   ZERO_C  = {CW{1'b0}};
   localparam logic [CW-1:0]   ONE_C   = CW'(1'b1);
   localparam logic [PW-1:0]   ZERO_P  = {PW{1'b0}};
   localparam logic [PW-1:0]   ONE_P   = PW'(1'b1);

   logic [XLEN-1:0] mem_pc_r   [DEPTH];
   logic [XLEN-1:0] mem_inst_r [DEPTH];
   logic [PW-1:0]   head_r;
   logic [PW-1:0]   tail_r;
   logic [CW-1:0]   count_r;
   logic [CW-1:0]   outstanding_r;
   logic [CW-1:0]   discard_r;
   logic [XLEN-1:0] fetch_pc_r;
   logic [XLEN-1:0] resp_pc_r;

   logic            credit_s;
   logic            req_s;
   logic            grant_s;
   logic            push_s;
   logic            pop_s;
   logic [XLEN-1:0] redirect_base_s;
   logic [CW-1:0]   count_nxt_s;
   logic [CW-1:0]   outstanding_nxt_s;
   logic [CW-1:0]   discard_nxt_s;

   // Handshake qualification and next values of the occupancy/in-flight/squash counters.
   always_comb begin
      // Discarded in-flight requests still hold credit until their responses come back.
      credit_s        = ({1'b0, count_r} + {1'b0, outstanding_r}) < DEPTH_C;
      req_s           = ~rst & ~bus.redirect_i & credit_s;
      grant_s         = req_s & bus.imem_gnt_i;
      pop_s           = (count_r != ZERO_C) & bus.inst_ready_i & ~bus.redirect_i;
      push_s          = bus.imem_rvalid_i & ~bus.redirect_i & (discard_r == ZERO_C);
      redirect_base_s = bus.redirect_pc_i & ALIGN_M;

      outstanding_nxt_s = outstanding_r;
      if (grant_s & ~bus.imem_rvalid_i) begin
         outstanding_nxt_s = outstanding_r + ONE_C;
      end else if (~grant_s & bus.imem_rvalid_i) begin
         outstanding_nxt_s = outstanding_r - ONE_C;
      end else begin
         outstanding_nxt_s = outstanding_r;
      end

      discard_nxt_s = discard_r;
      if (bus.redirect_i) begin
         discard_nxt_s = outstanding_r - (bus.imem_rvalid_i ? ONE_C : ZERO_C);
      end else if (bus.imem_rvalid_i & (discard_r != ZERO_C)) begin
         discard_nxt_s = discard_r - ONE_C;
      end else begin
         discard_nxt_s = discard_r;
      end

      count_nxt_s = count_r;
      if (bus.redirect_i) begin
         count_nxt_s = ZERO_C;
      end else if (push_s & ~pop_s) begin
         count_nxt_s = count_r + ONE_C;
      end else if (pop_s & ~push_s) begin
         count_nxt_s = count_r - ONE_C;
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Counters, fetch/response PCs and ring pointers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r       <= ZERO_C;
         outstanding_r <= ZERO_C;
         discard_r     <= ZERO_C;
         fetch_pc_r    <= RESET_PC;
         resp_pc_r     <= RESET_PC;
         head_r        <= ZERO_P;
         tail_r        <= ZERO_P;
      end else begin
         count_r       <= count_nxt_s;
         outstanding_r <= outstanding_nxt_s;
         discard_r     <= discard_nxt_s;
         if (bus.redirect_i) begin
            fetch_pc_r <= redirect_base_s;
            resp_pc_r  <= redirect_base_s;
            head_r     <= ZERO_P;
            tail_r     <= ZERO_P;
         end else begin
            if (grant_s) begin
               fetch_pc_r <= fetch_pc_r + STEP;
            end else begin
               fetch_pc_r <= fetch_pc_r;
            end
            if (push_s) begin
               resp_pc_r <= resp_pc_r + STEP;
               tail_r    <= tail_r + ONE_P;
            end else begin
               resp_pc_r <= resp_pc_r;
               tail_r    <= tail_r;
            end
            if (pop_s) begin
               head_r <= head_r + ONE_P;
            end else begin
               head_r <= head_r;
            end
         end
      end
   end

   // Entry storage; an accepted response is written at the tail with its fetch address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_pc_r[i]   <= ZERO_X;
            mem_inst_r[i] <= ZERO_X;
         end
      end else if (push_s) begin
         mem_pc_r[tail_r]   <= resp_pc_r;
         mem_inst_r[tail_r] <= bus.imem_rdata_i;
      end else begin
         mem_pc_r[tail_r]   <= mem_pc_r[tail_r];
         mem_inst_r[tail_r] <= mem_inst_r[tail_r];
      end
   end

   assign bus.imem_req_o   = req_s;
   assign bus.imem_addr_o  = fetch_pc_r;
   assign bus.inst_valid_o = (count_r != ZERO_C);
   assign bus.inst_o       = mem_inst_r[head_r];
   assign bus.pc_o         = mem_pc_r[head_r];
   assign bus.count_o      = count_r;
endmodule
